id_branch_resolve_unit: RTL and testbench
=========================================

Name: id_branch_resolve_unit

Overview:
- Parametrised ID-stage branch resolution unit for the MIPS32 pipeline; replaces the single-mux, equality-only comparator.
- Selects each comparand from the register file or from one of NUM_FWD forwarded stage results, then evaluates all MIPS branch conditions.
- Stalls ID while operands are pending and issues registered taken/target/flush signals to IF.
- Keeps saturating branch statistics and a sticky wait-timeout error.

Parameters:
- DATA_W, 32, operand and target width.
- NUM_FWD, 2, number of forwarded sources (1=MEM, 2=WB, ...).
- MAX_WAIT, 3, stall cycles allowed before Wait_Timeout_Err sets.
- CNT_W, 16, statistics counter width.
- DELAY_SLOT, 1, 1 = MIPS delay slot, no IF flush; 0 = flush and shadow suppression.

Ports:
- Clk  in  1  pipeline clock, rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- Branch_Valid_ID  in  1  ID holds a branch/jump-compare instruction.
- Branch_Op_ID  in  3  condition code (see Behaviour).
- Read_Data_1_ID  in  DATA_W  register-file rs value.
- Read_Data_2_ID  in  DATA_W  register-file rt value.
- Fwd_Data_ID  in  NUM_FWD*DATA_W  forwarded results; source k occupies slice [(k-1)*DATA_W +: DATA_W].
- Forward_C_ID  in  SEL_W  rs select: 0 = register file, k = source k.
- Forward_D_ID  in  SEL_W  rt select, same encoding.
- Operand_Ready_ID  in  1  hazard unit: all selected operands valid this cycle.
- Branch_Target_ID  in  DATA_W  computed target address.
- Clear_Stats  in  1  synchronous clear of the counters and the error flag.
- Stall_ID  out  1  combinational; holds the PC and IF/ID registers.
- Cmp_Eq_ID  out  1  combinational; muxed rs == muxed rt.
- Branch_Taken_IF  out  1  registered one-cycle pulse.
- Branch_Target_IF  out  DATA_W  registered; last taken target.
- Flush_IF  out  1  registered pulse.
- Branch_Count  out  CNT_W  number of resolved branches.
- Taken_Count  out  CNT_W  number of taken branches.
- Wait_Timeout_Err  out  1  sticky.

Behaviour:
- SEL_W = $clog2(NUM_FWD+1).
- A select value greater than NUM_FWD selects the register file.
- Branch_Op_ID encoding (signed compares use muxed rs only):
  - 000 EQ; 001 NE; 010 LTZ; 011 GEZ; 100 GTZ; 101 LEZ; 110 ALWAYS.
  - 111 is reserved: treated as not taken, but still counted as resolved.
- Effective valid: Branch_Valid_ID, ANDed with !Branch_Taken_IF when DELAY_SLOT=0.
- Stall_ID = effective valid & !Operand_Ready_ID, in either state.
- FSM states IDLE and WAIT:
  - IDLE, valid & !ready: go to WAIT, wait_cnt=1.
  - IDLE, valid & ready: resolve this cycle, stay in IDLE.
  - WAIT, valid & ready: resolve, go to IDLE, wait_cnt=0.
  - WAIT, valid & !ready: wait_cnt increments and saturates at MAX_WAIT. When wait_cnt==MAX_WAIT and still !ready, Wait_Timeout_Err sets and the stall continues.
  - WAIT, valid drops (upstream squash): go to IDLE, no resolution, no count.
- Resolution (outputs registered, visible the next cycle):
  - Branch_Count increments.
  - If taken: Branch_Taken_IF=1, Branch_Target_IF=Branch_Target_ID, Taken_Count increments, and Flush_IF=1 when DELAY_SLOT=0.
  - If not taken: pulses are 0 and Branch_Target_IF holds its value.
- Latency: 1 cycle from a ready resolution to the pulse. Back-to-back resolutions allowed every cycle when DELAY_SLOT=1.
- Counters saturate at all-ones and do not wrap.
- Clear_Stats in the same cycle as a resolution: clear wins, both counters become 0.
- Clear_Stats also clears Wait_Timeout_Err.
- Reset value of every registered output is 0: Branch_Taken_IF, Flush_IF, Branch_Target_IF, both counters, Wait_Timeout_Err. State=IDLE, wait_cnt=0.
- Reset asserted mid-WAIT aborts immediately. Stall_ID still follows its combinational equation.

Decomposition:
- Shared package branch_pkg:
  - Branch_Op encoding localparams BR_EQ..BR_RSVD.
  - FSM state encoding.
  - SEL_W helper function.
- One sub-module, branch_cond_eval: combinational operand muxes and condition evaluation, returning taken and Cmp_Eq.
- The top level holds the FSM, output registers and counters.

Test Plan:
- Forward_C=1 selects MEM, Forward_D=0, MEM=0x5, rt=0x5, EQ, ready -> next cycle Taken=1, Target=Branch_Target_ID, Branch_Count=1, Taken_Count=1.
- rs=0xFFFFFFFF across ops LTZ, GEZ, GTZ, LEZ, ALWAYS, 111, all ready -> Taken pulses 1,0,0,1,1,0; Branch_Count=6, Taken_Count=3.
- Valid with ready low for 4 cycles, MAX_WAIT=3 -> Stall_ID high for 4 cycles, Wait_Timeout_Err sets after the 3rd wait cycle, then resolves once ready; Clear_Stats clears the flag.
- Forward_D=3 with NUM_FWD=2, rt=7, rs=7, NE -> select treated as register file, Taken=0, Cmp_Eq_ID=1.
- DELAY_SLOT=0, taken branch followed by a valid branch in the next cycle -> Flush_IF pulses once, second branch ignored, Branch_Count=1.
- Reset_n low mid-WAIT -> outputs 0 immediately; Branch_Count preset near all-ones plus 3 resolutions -> holds all-ones; Clear_Stats with a resolution -> 0.

Source files
------------

// File: rtl/branch_pkg.sv
// Shared definitions for the ID-stage branch resolution unit: condition codes,
// FSM state encoding and the forwarding-select width helper.
package branch_pkg;

   localparam logic [2:0] BR_EQ     = 3'b000;
   localparam logic [2:0] BR_NE     = 3'b001;
   localparam logic [2:0] BR_LTZ    = 3'b010;
   localparam logic [2:0] BR_GEZ    = 3'b011;
   localparam logic [2:0] BR_GTZ    = 3'b100;
   localparam logic [2:0] BR_LEZ    = 3'b101;
   localparam logic [2:0] BR_ALWAYS = 3'b110;
   localparam logic [2:0] BR_RSVD   = 3'b111;

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_WAIT = 1'b1;

   // Select 0 is the register file, 1..num_fwd are the forwarded sources.
   function automatic int sel_width(input int num_fwd);
      return (num_fwd < 1) ? 1 : $clog2(num_fwd + 1);
   endfunction

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational comparand selection (register file or forwarded result) and
// evaluation of every MIPS branch condition on the selected operands.
module branch_cond_eval
   import branch_pkg::*;
#(
   parameter int DATA_W  = 32,
   parameter int NUM_FWD = 2,
   parameter int SEL_W   = sel_width(NUM_FWD)
) (
   input  logic [DATA_W-1:0]         rf_rs_i,
   input  logic [DATA_W-1:0]         rf_rt_i,
   input  logic [NUM_FWD*DATA_W-1:0] fwd_data_i,
   input  logic [SEL_W-1:0]          sel_rs_i,
   input  logic [SEL_W-1:0]          sel_rt_i,
   input  logic [2:0]                op_i,
   output logic                      taken_o,
   output logic                      cmp_eq_o
);

   logic [DATA_W-1:0] rs;
   logic [DATA_W-1:0] rt;
   logic              rs_neg;
   logic              rs_zero;

   // Out-of-range selects never match a source and fall back to the register file.
   always_comb begin
      rs = rf_rs_i;
      rt = rf_rt_i;
      for (int k = 1; k <= NUM_FWD; k++) begin
         if (int'(sel_rs_i) == k) rs = fwd_data_i[(k-1)*DATA_W +: DATA_W];
         if (int'(sel_rt_i) == k) rt = fwd_data_i[(k-1)*DATA_W +: DATA_W];
      end
   end

   assign cmp_eq_o = (rs == rt);
   assign rs_neg   = rs[DATA_W-1];
   assign rs_zero  = (rs == '0);

   always_comb begin
      taken_o = 1'b0;
      case (op_i)
         BR_EQ:     taken_o = cmp_eq_o;
         BR_NE:     taken_o = ~cmp_eq_o;
         BR_LTZ:    taken_o = rs_neg;
         BR_GEZ:    taken_o = ~rs_neg;
         BR_GTZ:    taken_o = ~rs_neg & ~rs_zero;
         BR_LEZ:    taken_o = rs_neg | rs_zero;
         BR_ALWAYS: taken_o = 1'b1;
         default:   taken_o = 1'b0;
      endcase
   end

endmodule

// File: rtl/id_branch_resolve_unit.sv
// ID-stage branch resolution: operand-wait FSM, registered taken/target/flush
// pulses to IF, saturating branch statistics and a sticky wait-timeout flag.
module id_branch_resolve_unit
   import branch_pkg::*;
#(
   parameter int DATA_W     = 32,
   parameter int NUM_FWD    = 2,
   parameter int MAX_WAIT   = 3,
   parameter int CNT_W      = 16,
   parameter int DELAY_SLOT = 1,
   localparam int SEL_W     = sel_width(NUM_FWD)
) (
   input  logic                      Clk,
   input  logic                      Reset_n,
   input  logic                      Branch_Valid_ID,
   input  logic [2:0]                Branch_Op_ID,
   input  logic [DATA_W-1:0]         Read_Data_1_ID,
   input  logic [DATA_W-1:0]         Read_Data_2_ID,
   input  logic [NUM_FWD*DATA_W-1:0] Fwd_Data_ID,
   input  logic [SEL_W-1:0]          Forward_C_ID,
   input  logic [SEL_W-1:0]          Forward_D_ID,
   input  logic                      Operand_Ready_ID,
   input  logic [DATA_W-1:0]         Branch_Target_ID,
   input  logic                      Clear_Stats,
   output logic                      Stall_ID,
   output logic                      Cmp_Eq_ID,
   output logic                      Branch_Taken_IF,
   output logic [DATA_W-1:0]         Branch_Target_IF,
   output logic                      Flush_IF,
   output logic [CNT_W-1:0]          Branch_Count,
   output logic [CNT_W-1:0]          Taken_Count,
   output logic                      Wait_Timeout_Err,
   output logic [0:0]                Fsm_State_Dbg
);

   localparam int WCNT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);

   logic [0:0]        state_q,    state_d;
   logic [WCNT_W-1:0] wait_cnt_q, wait_cnt_d;
   logic              taken_q,    taken_d;
   logic              flush_q,    flush_d;
   logic [DATA_W-1:0] target_q,   target_d;
   logic [CNT_W-1:0]  br_cnt_q,   br_cnt_d;
   logic [CNT_W-1:0]  tk_cnt_q,   tk_cnt_d;
   logic              err_q,      err_d;
   logic              eff_valid;
   logic              resolve;
   logic              cond_taken;

   branch_cond_eval #(
      .DATA_W  (DATA_W),
      .NUM_FWD (NUM_FWD),
      .SEL_W   (SEL_W)
   ) u_cond (
      .rf_rs_i    (Read_Data_1_ID),
      .rf_rt_i    (Read_Data_2_ID),
      .fwd_data_i (Fwd_Data_ID),
      .sel_rs_i   (Forward_C_ID),
      .sel_rt_i   (Forward_D_ID),
      .op_i       (Branch_Op_ID),
      .taken_o    (cond_taken),
      .cmp_eq_o   (Cmp_Eq_ID)
   );

   // Handshake: a branch resolves on any cycle where effective valid and
   // Operand_Ready_ID are both high; valid without ready stalls ID, and ID
   // must hold the branch and its inputs stable until it resolves or is squashed.
   assign eff_valid = Branch_Valid_ID & ((DELAY_SLOT != 0) | ~taken_q);
   assign resolve   = eff_valid & Operand_Ready_ID;
   assign Stall_ID  = eff_valid & ~Operand_Ready_ID;

   always_comb begin
      state_d    = state_q;
      wait_cnt_d = wait_cnt_q;
      err_d      = err_q;
      case (state_q)
         ST_IDLE: begin
            if (Stall_ID) begin
               state_d    = ST_WAIT;
               wait_cnt_d = WCNT_W'(1);
            end
         end
         default: begin
            if (!eff_valid || resolve) begin
               state_d    = ST_IDLE;
               wait_cnt_d = '0;
            end else if (wait_cnt_q == WCNT_W'(MAX_WAIT)) begin
               err_d = 1'b1;
            end else begin
               wait_cnt_d = wait_cnt_q + 1'b1;
            end
         end
      endcase
      if (Clear_Stats) err_d = 1'b0;
   end

   // Clear has priority over a same-cycle resolution; counters saturate.
   always_comb begin
      br_cnt_d = br_cnt_q;
      tk_cnt_d = tk_cnt_q;
      taken_d  = resolve & cond_taken;
      flush_d  = resolve & cond_taken & (DELAY_SLOT == 0);
      target_d = (resolve & cond_taken) ? Branch_Target_ID : target_q;
      if (Clear_Stats) begin
         br_cnt_d = '0;
         tk_cnt_d = '0;
      end else if (resolve) begin
         if (br_cnt_q != '1) br_cnt_d = br_cnt_q + 1'b1;
         if (cond_taken && (tk_cnt_q != '1)) tk_cnt_d = tk_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q    <= ST_IDLE;
         wait_cnt_q <= '0;
         taken_q    <= 1'b0;
         flush_q    <= 1'b0;
         target_q   <= '0;
         br_cnt_q   <= '0;
         tk_cnt_q   <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
         taken_q    <= taken_d;
         flush_q    <= flush_d;
         target_q   <= target_d;
         br_cnt_q   <= br_cnt_d;
         tk_cnt_q   <= tk_cnt_d;
         err_q      <= err_d;
      end
   end

   assign Branch_Taken_IF  = taken_q;
   assign Flush_IF         = flush_q;
   assign Branch_Target_IF = target_q;
   assign Branch_Count     = br_cnt_q;
   assign Taken_Count      = tk_cnt_q;
   assign Wait_Timeout_Err = err_q;
   assign Fsm_State_Dbg    = state_q;

endmodule

// File: tb/tb_id_branch_resolve_unit.sv
// Bench for id_branch_resolve_unit: a delay-slot and a flushing instance share
// one stimulus stream and are checked against a behavioural model via a scoreboard.
module tb_id_branch_resolve_unit;

   localparam int DW   = 32;
   localparam int NF   = 2;
   localparam int MW   = 3;
   localparam int CW   = 4;
   localparam int CMAX = (1 << CW) - 1;

   typedef struct packed {
      logic          stall;
      logic          eq;
      logic          tk;
      logic          fl;
      logic          err;
      logic          st;
      logic [CW-1:0] bc;
      logic [CW-1:0] tc;
      logic [DW-1:0] tgt;
   } exp_t;

   exp_t exp_q[$];
   int   n_vec = 0;
   int   n_err = 0;

   logic          Clk = 1'b0;
   logic          Reset_n = 1'b0;
   logic          v_r = 1'b0;
   logic [2:0]    op_r = '0;
   logic [DW-1:0] rs_r = '0, rt_r = '0, mem_r = '0, wb_r = '0, tgt_r = '0;
   logic [1:0]    fc_r = '0, fd_r = '0;
   logic          rdy_r = 1'b0;
   logic          clr_r = 1'b0;

   logic [1:0]    stall, cmpeq, tk, fl, err;
   logic [0:0]    st [2];
   logic [DW-1:0] tgt [2];
   logic [CW-1:0] bc [2];
   logic [CW-1:0] tc [2];

   // Model state, index 0 = delay-slot instance, 1 = flushing instance.
   bit            m_wait [2];
   int            m_wcnt [2];
   bit            m_err  [2];
   int            m_bc   [2];
   int            m_tc   [2];
   bit            m_tk   [2];
   bit            m_fl   [2];
   logic [DW-1:0] m_tgt  [2];

   always #5 Clk = ~Clk;

   for (genvar g = 0; g < 2; g++) begin : g_dut
      id_branch_resolve_unit #(
         .DATA_W(DW), .NUM_FWD(NF), .MAX_WAIT(MW), .CNT_W(CW), .DELAY_SLOT(g == 0 ? 1 : 0)
      ) dut (
         .Clk              (Clk),
         .Reset_n          (Reset_n),
         .Branch_Valid_ID  (v_r),
         .Branch_Op_ID     (op_r),
         .Read_Data_1_ID   (rs_r),
         .Read_Data_2_ID   (rt_r),
         .Fwd_Data_ID      ({wb_r, mem_r}),
         .Forward_C_ID     (fc_r),
         .Forward_D_ID     (fd_r),
         .Operand_Ready_ID (rdy_r),
         .Branch_Target_ID (tgt_r),
         .Clear_Stats      (clr_r),
         .Stall_ID         (stall[g]),
         .Cmp_Eq_ID        (cmpeq[g]),
         .Branch_Taken_IF  (tk[g]),
         .Branch_Target_IF (tgt[g]),
         .Flush_IF         (fl[g]),
         .Branch_Count     (bc[g]),
         .Taken_Count      (tc[g]),
         .Wait_Timeout_Err (err[g]),
         .Fsm_State_Dbg    (st[g])
      );
   end

   function automatic logic [DW-1:0] pick(input logic [1:0] sel, input logic [DW-1:0] rf);
      case (sel)
         2'd1:    return mem_r;
         2'd2:    return wb_r;
         default: return rf;
      endcase
   endfunction

   function automatic bit br_cond(input logic [2:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
      int s;
      s = $signed(a);
      case (op)
         3'd0:    return a == b;
         3'd1:    return a != b;
         3'd2:    return s < 0;
         3'd3:    return s >= 0;
         3'd4:    return s > 0;
         3'd5:    return s <= 0;
         3'd6:    return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         m_wait[d] = 0; m_wcnt[d] = 0; m_err[d] = 0; m_bc[d] = 0;
         m_tc[d] = 0; m_tk[d] = 0; m_fl[d] = 0; m_tgt[d] = '0;
      end
   endtask

   task automatic model_step(input int d, input bit ev, input bit rdy, input bit cond,
                             input bit clr, input logic [DW-1:0] target);
      bit res;
      res = ev && rdy;
      if (ev && !rdy) begin
         if (!m_wait[d]) begin
            m_wait[d] = 1; m_wcnt[d] = 1;
         end else if (m_wcnt[d] == MW) begin
            m_err[d] = 1;
         end else begin
            m_wcnt[d]++;
         end
      end else begin
         m_wait[d] = 0; m_wcnt[d] = 0;
      end
      if (clr) begin
         m_bc[d] = 0; m_tc[d] = 0; m_err[d] = 0;
      end else if (res) begin
         if (m_bc[d] < CMAX) m_bc[d]++;
         if (cond && m_tc[d] < CMAX) m_tc[d]++;
      end
      m_tk[d] = res && cond;
      m_fl[d] = res && cond && (d == 1);
      if (res && cond) m_tgt[d] = target;
   endtask

   // One clock of stimulus: apply inputs, push this cycle's expectations,
   // then advance the model across the rising edge.
   task automatic drive(input bit rst, input bit v, input logic [2:0] op,
                        input logic [DW-1:0] rs, input logic [DW-1:0] rt,
                        input logic [DW-1:0] mem, input logic [DW-1:0] wb,
                        input logic [1:0] fc, input logic [1:0] fd,
                        input bit rdy, input bit clr, input logic [DW-1:0] target);
      exp_t          e;
      logic [DW-1:0] a, b;
      bit            ev [2];
      bit            cond;
      Reset_n = !rst; v_r = v; op_r = op; rs_r = rs; rt_r = rt; mem_r = mem; wb_r = wb;
      fc_r = fc; fd_r = fd; rdy_r = rdy; clr_r = clr; tgt_r = target;
      if (rst) model_reset();
      a = pick(fc, rs);
      b = pick(fd, rt);
      cond = br_cond(op, a, b);
      for (int d = 0; d < 2; d++) begin
         ev[d]   = v && (d == 0 || !m_tk[d]);
         e.stall = ev[d] && !rdy;
         e.eq    = (a == b);
         e.tk    = m_tk[d];
         e.fl    = m_fl[d];
         e.err   = m_err[d];
         e.st    = m_wait[d];
         e.bc    = CW'(m_bc[d]);
         e.tc    = CW'(m_tc[d]);
         e.tgt   = m_tgt[d];
         exp_q.push_back(e);
      end
      @(posedge Clk);
      if (!rst) for (int d = 0; d < 2; d++) model_step(d, ev[d], rdy, cond, clr, target);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(0, 0, 3'd0, '0, '0, '0, '0, 2'd0, 2'd0, 1, 0, '0);
   endtask

   task automatic chk(input string name, input int d, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s ds_inst%0d @%0t: got %0h, expected %0h", name, d, $time, act, exp);
      end
   endtask

   always @(negedge Clk) begin
      exp_t e;
      for (int d = 0; d < 2; d++) begin
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("stall",  d, DW'(stall[d]), DW'(e.stall));
            chk("cmp_eq", d, DW'(cmpeq[d]), DW'(e.eq));
            chk("taken",  d, DW'(tk[d]),    DW'(e.tk));
            chk("flush",  d, DW'(fl[d]),    DW'(e.fl));
            chk("err",    d, DW'(err[d]),   DW'(e.err));
            chk("state",  d, DW'(st[d]),    DW'(e.st));
            chk("br_cnt", d, DW'(bc[d]),    DW'(e.bc));
            chk("tk_cnt", d, DW'(tc[d]),    DW'(e.tc));
            chk("target", d, tgt[d],        e.tgt);
         end
      end
   end

   initial begin
      logic [DW-1:0] pool [6];
      pool[0] = 32'h0; pool[1] = 32'h1; pool[2] = 32'hFFFF_FFFF;
      pool[3] = 32'h8000_0000; pool[4] = 32'h7FFF_FFFF; pool[5] = 32'h5;
      model_reset();
      @(posedge Clk);
      #1;
      for (int i = 0; i < 2; i++) drive(1, 0, 3'd0, '0, '0, '0, '0, 2'd0, 2'd0, 0, 0, '0);
      idle(1);

      // EQ with rs forwarded from MEM.
      drive(0, 1, 3'd0, 32'h0, 32'h5, 32'h5, 32'h9, 2'd1, 2'd0, 1, 0, 32'h0000_0400);
      idle(2);

      // Sign tests on rs = -1, including the reserved code.
      for (int op = 2; op <= 7; op++)
         drive(0, 1, 3'(op), 32'hFFFF_FFFF, 32'h0, '0, '0, 2'd0, 2'd0, 1, 0, 32'h1000 + DW'(op));
      idle(2);

      // Operand wait past the timeout, then resolve, then clear.
      for (int i = 0; i < 4; i++) drive(0, 1, 3'd6, '0, '0, '0, '0, 2'd0, 2'd0, 0, 0, 32'h2000);
      drive(0, 1, 3'd6, '0, '0, '0, '0, 2'd0, 2'd0, 1, 0, 32'h2000);
      idle(2);
      drive(0, 0, 3'd0, '0, '0, '0, '0, 2'd0, 2'd0, 1, 1, '0);
      idle(1);

      // Out-of-range rt select falls back to the register file.
      drive(0, 1, 3'd1, 32'h7, 32'h7, 32'h3, 32'h4, 2'd0, 2'd3, 1, 0, 32'h3000);
      idle(2);

      // Back-to-back taken branches: the flushing instance drops the second.
      drive(0, 1, 3'd6, '0, '0, '0, '0, 2'd0, 2'd0, 1, 1, 32'h4000);
      drive(0, 1, 3'd6, '0, '0, '0, '0, 2'd0, 2'd0, 1, 0, 32'h4004);
      idle(2);

      // Reset in the middle of a wait.
      for (int i = 0; i < 2; i++) drive(0, 1, 3'd0, '0, '0, '0, '0, 2'd0, 2'd0, 0, 0, 32'h5000);
      drive(1, 1, 3'd0, '0, '0, '0, '0, 2'd0, 2'd0, 0, 0, 32'h5000);
      idle(1);

      // Saturate both counters, then clear alongside a resolution.
      for (int i = 0; i < 34; i++) drive(0, 1, 3'd6, '0, '0, '0, '0, 2'd0, 2'd0, 1, 0, 32'h6000 + DW'(i));
      idle(1);
      drive(0, 1, 3'd6, '0, '0, '0, '0, 2'd0, 2'd0, 1, 1, 32'h7000);
      idle(2);

      for (int i = 0; i < 600; i++) begin
         logic [DW-1:0] rs, rt, mem, wb;
         rs  = ($urandom_range(0, 3) == 0) ? DW'($urandom) : pool[$urandom_range(0, 5)];
         rt  = ($urandom_range(0, 3) == 0) ? DW'($urandom) : pool[$urandom_range(0, 5)];
         mem = pool[$urandom_range(0, 5)];
         wb  = pool[$urandom_range(0, 5)];
         drive($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)),
               rs, rt, mem, wb, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
               $urandom_range(0, 3) != 0, $urandom_range(0, 31) == 0, DW'($urandom));
      end
      idle(3);
      @(negedge Clk);
      #1;
      n_vec++;
      if (exp_q.size() != 0) begin
         n_err++;
         $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
